// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction memory read bus between the fetch stage (master) and instruction memory (slave)
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ack;
    modport master (output req, output addr, input rdata, input ack);
    modport slave (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: IDLE/REQ/HOLD fetch FSM with single-entry stall buffer; define IF_MISALIGN_TRAP_EN to trap misaligned redirects
module if_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    if_fetch_stage_if.master imem,
    output logic [31:0]      pc_out,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    output logic             misalign_trap
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] pc_out_d, instr_d;
    logic        valid_d;
    logic [31:0] hold_pc, hold_pc_d, hold_instr, hold_instr_d;
    logic [31:0] redirect_tgt;
    logic        misaligned;
`ifdef IF_MISALIGN_TRAP_EN
    assign misaligned   = redirect_en && (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
    // one-cycle pulse for each rejected misaligned redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_trap <= 1'b0;
        else     misalign_trap <= misaligned;
    end
`else
    assign misaligned    = 1'b0;
    assign redirect_tgt  = redirect_pc & ~32'h3;
    assign misalign_trap = 1'b0;
`endif
    assign imem.req  = state == REQ;
    assign imem.addr = pc;
    // next state and next register values; redirect overrides stall and ack
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        pc_out_d     = pc_out;
        instr_d      = instr_out;
        valid_d      = instr_valid;
        hold_pc_d    = hold_pc;
        hold_instr_d = hold_instr;
        if (redirect_en) begin
            state_d = REQ;
            pc_d    = misaligned ? pc : redirect_tgt;
            valid_d = 1'b0;
        end else begin
            case (state)
                IDLE: state_d = REQ;
                REQ: begin
                    if (!stall) begin
                        valid_d = imem.ack;
                        if (imem.ack) begin
                            pc_out_d = pc;
                            instr_d  = imem.rdata;
                            pc_d     = pc + 32'd4;
                        end
                    end else if (imem.ack) begin
                        hold_pc_d    = pc;
                        hold_instr_d = imem.rdata;
                        pc_d         = pc + 32'd4;
                        state_d      = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_out_d = hold_pc;
                        instr_d  = hold_instr;
                        valid_d  = 1'b1;
                        state_d  = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state, pc, output and buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            pc_out      <= RESET_VECTOR;
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            hold_pc     <= 32'h0;
            hold_instr  <= 32'h0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            pc_out      <= pc_out_d;
            instr_out   <= instr_d;
            instr_valid <= valid_d;
            hold_pc     <= hold_pc_d;
            hold_instr  <= hold_instr_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for if_fetch_stage (main DUT at vector 0, second DUT at vector FFFF_FFF8)
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, instr_out, pc_out2, instr_out2;
    logic        instr_valid, misalign_trap, instr_valid2, misalign_trap2;
    int          compared = 0;
    int          mismatched = 0;
    int          ack_delay = 0;
    int          cnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] q[$];
    logic [31:0] e;

    if_fetch_stage_if bus();
    if_fetch_stage_if bus2();

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem(bus), .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid), .misalign_trap(misalign_trap)
    );
    if_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem(bus2), .pc_out(pc_out2), .instr_out(instr_out2), .instr_valid(instr_valid2), .misalign_trap(misalign_trap2)
    );

    always #5 clk = ~clk;

    // memory model: ack after ack_delay waiting cycles, data derived from address
    always @(posedge clk) cnt <= (rst || !bus.req || bus.ack) ? 0 : cnt + 1;
    assign bus.ack    = bus.req && (cnt >= ack_delay);
    assign bus.rdata  = 32'hA000_0000 + bus.addr;
    assign bus2.ack   = bus2.req;
    assign bus2.rdata = 32'hA000_0000 + bus2.addr;

    // scoreboard: an instruction is consumed when valid and decode accepts it
    always @(negedge clk) begin
        if (mon_en && !rst && instr_valid && !stall && !redirect_en) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no instruction", pc_out, instr_out);
            end else begin
                e = q.pop_front();
                if (pc_out !== e || instr_out !== 32'hA000_0000 + e) begin
                    mismatched++;
                    $display("FAIL sb_instr: got pc=%h instr=%h, required pc=%h instr=%h", pc_out, instr_out, e, 32'hA000_0000 + e);
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_en = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        ack_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        compared += 6;
        if (pc_out !== 32'h0) begin mismatched++; $display("FAIL rst_pc_out: got %h, required 00000000", pc_out); end
        if (instr_out !== 32'h13) begin mismatched++; $display("FAIL rst_instr_out: got %h, required 00000013", instr_out); end
        if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
        if (misalign_trap !== 1'b0) begin mismatched++; $display("FAIL rst_trap: got %b, required 0", misalign_trap); end
        if (bus.req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b, required 0", bus.req); end
        if (pc_out2 !== 32'hFFFF_FFF8) begin mismatched++; $display("FAIL rst_pc_out2: got %h, required fffffff8", pc_out2); end
        rst = 1'b0;
        @(negedge clk); #1;
        compared++;
        if (bus.req !== 1'b0) begin mismatched++; $display("FAIL idle_req: got %b, required 0", bus.req); end
        @(negedge clk); #1;
        compared += 2;
        if (bus.req !== 1'b1) begin mismatched++; $display("FAIL req_state_req: got %b, required 1", bus.req); end
        if (bus.addr !== 32'h0) begin mismatched++; $display("FAIL req_state_addr: got %h, required 00000000", bus.addr); end
        @(negedge clk); #1;
        compared += 2;
        if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL first_valid_cyc3: got %b, required 1", instr_valid); end
        if (instr_out !== 32'hA000_0000) begin mismatched++; $display("FAIL first_instr: got %h, required a0000000", instr_out); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        compared += 4;
        if (pc_out !== 32'h0) begin mismatched++; $display("FAIL async_rst_pc_out: got %h, required 00000000", pc_out); end
        if (instr_out !== 32'h13) begin mismatched++; $display("FAIL async_rst_instr: got %h, required 00000013", instr_out); end
        if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL async_rst_valid: got %b, required 0", instr_valid); end
        if (bus.req !== 1'b0) begin mismatched++; $display("FAIL async_rst_req: got %b, required 0", bus.req); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_stream();
        int done = 0;
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 8; i++) q.push_back(32'(4 * i));
        mon_en = 1'b1;
        for (int cyc = 1; cyc <= 30 && done == 0; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 2) begin
                compared++;
                if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL stream_cyc2_valid: got %b, required 0", instr_valid); end
            end
            if (q.size() == 0) begin done = cyc; mon_en = 1'b0; end
            @(posedge clk); #1;
        end
        compared++;
        if (done !== 10) begin mismatched++; $display("FAIL stream_drain_cycle: got %0d, required 10", done); end
    endtask

    task automatic test_delay();
        int done = 0;
        int nvalid = 0;
        do_reset();
        ack_delay = 3;
        for (int i = 0; i < 5; i++) q.push_back(32'(4 * i));
        mon_en = 1'b1;
        for (int cyc = 1; cyc <= 40 && done == 0; cyc++) begin
            @(negedge clk); #1;
            if (instr_valid) nvalid++;
            if (q.size() == 0) begin done = cyc; mon_en = 1'b0; end
            @(posedge clk); #1;
        end
        ack_delay = 0;
        compared += 2;
        if (done !== 22) begin mismatched++; $display("FAIL delay_drain_cycle: got %0d, required 22", done); end
        if (nvalid !== 5) begin mismatched++; $display("FAIL delay_valid_pulses: got %0d, required 5", nvalid); end
    endtask

    task automatic test_stall();
        int done = 0;
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 12; i++) q.push_back(32'(4 * i));
        mon_en = 1'b1;
        for (int cyc = 1; cyc <= 40 && done == 0; cyc++) begin
            stall = (cyc >= 6 && cyc <= 10);
            @(negedge clk); #1;
            if (cyc == 6) begin
                compared++;
                if (pc_out !== 32'd12) begin mismatched++; $display("FAIL stall_entry_pc_out: got %h, required 0000000c", pc_out); end
            end
            if (cyc == 8) begin
                compared += 3;
                if (bus.req !== 1'b0) begin mismatched++; $display("FAIL hold_req: got %b, required 0", bus.req); end
                if (pc_out !== 32'd12) begin mismatched++; $display("FAIL hold_pc_out: got %h, required 0000000c", pc_out); end
                if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL hold_valid: got %b, required 1", instr_valid); end
            end
            if (q.size() == 0) begin done = cyc; mon_en = 1'b0; end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        compared++;
        if (done !== 19) begin mismatched++; $display("FAIL stall_drain_cycle: got %0d, required 19", done); end
    endtask

    task automatic test_redirect();
        int done = 0;
        do_reset();
        ack_delay = 0;
        redirect_pc = 32'h0000_0100;
        q.push_back(32'h0);
        q.push_back(32'h4);
        for (int i = 0; i < 4; i++) q.push_back(32'h100 + 32'(4 * i));
        mon_en = 1'b1;
        for (int cyc = 1; cyc <= 30 && done == 0; cyc++) begin
            redirect_en = (cyc == 5);
            stall = (cyc == 5);
            @(negedge clk); #1;
            if (cyc == 6) begin
                compared += 2;
                if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL redirect_valid: got %b, required 0", instr_valid); end
                if (bus.addr !== 32'h100) begin mismatched++; $display("FAIL redirect_addr: got %h, required 00000100", bus.addr); end
            end
            if (q.size() == 0) begin done = cyc; mon_en = 1'b0; end
            @(posedge clk); #1;
        end
        redirect_en = 1'b0;
        stall = 1'b0;
        compared++;
        if (done !== 10) begin mismatched++; $display("FAIL redirect_drain_cycle: got %0d, required 10", done); end
    endtask

    task automatic test_misalign();
        int done = 0;
        do_reset();
        ack_delay = 0;
        redirect_pc = 32'h0000_0102;
        q.push_back(32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) q.push_back(32'd8 + 32'(4 * i));
`else
        for (int i = 0; i < 3; i++) q.push_back(32'h100 + 32'(4 * i));
`endif
        mon_en = 1'b1;
        for (int cyc = 1; cyc <= 30 && done == 0; cyc++) begin
            redirect_en = (cyc == 4);
            @(negedge clk); #1;
            if (cyc == 5) begin
                compared += 3;
                if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL misalign_valid: got %b, required 0", instr_valid); end
`ifdef IF_MISALIGN_TRAP_EN
                if (misalign_trap !== 1'b1) begin mismatched++; $display("FAIL misalign_trap_set: got %b, required 1", misalign_trap); end
                if (bus.addr !== 32'h8) begin mismatched++; $display("FAIL misalign_addr: got %h, required 00000008", bus.addr); end
`else
                if (misalign_trap !== 1'b0) begin mismatched++; $display("FAIL misalign_trap_tied: got %b, required 0", misalign_trap); end
                if (bus.addr !== 32'h100) begin mismatched++; $display("FAIL misalign_addr: got %h, required 00000100", bus.addr); end
`endif
            end
            if (cyc == 6) begin
                compared++;
                if (misalign_trap !== 1'b0) begin mismatched++; $display("FAIL misalign_trap_pulse: got %b, required 0", misalign_trap); end
            end
            if (q.size() == 0) begin done = cyc; mon_en = 1'b0; end
            @(posedge clk); #1;
        end
        redirect_en = 1'b0;
        compared++;
        if (done !== 8) begin mismatched++; $display("FAIL misalign_drain_cycle: got %0d, required 8", done); end
    endtask

    task automatic test_wrap();
        logic [31:0] x;
        do_reset();
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk); #1;
            if (cyc >= 3) begin
                x = 32'hFFFF_FFF8 + 32'(4 * (cyc - 3));
                compared += 3;
                if (instr_valid2 !== 1'b1) begin mismatched++; $display("FAIL wrap_valid_c%0d: got %b, required 1", cyc, instr_valid2); end
                if (pc_out2 !== x) begin mismatched++; $display("FAIL wrap_pc_c%0d: got %h, required %h", cyc, pc_out2, x); end
                if (instr_out2 !== 32'hA000_0000 + x) begin mismatched++; $display("FAIL wrap_instr_c%0d: got %h, required %h", cyc, instr_out2, 32'hA000_0000 + x); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_delay();
        test_stall();
        test_redirect();
        test_misalign();
        test_wrap();
        compared++;
        if (q.size() !== 0) begin mismatched++; $display("FAIL sb_leftover: got %0d pending, required 0", q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-004 stall  in  1  SHALL, when high, freeze the downstream outputs (decode not ready).
REQ-005 redirect_en  in  1  SHALL, when high, mark a taken branch or jump this cycle.
REQ-006 redirect_pc  in  32  SHALL be the branch or jump target, sampled when redirect_en=1.
REQ-007 imem_req  out  1  SHALL be the instruction memory read request.
REQ-008 imem_addr  out  32  SHALL be the word address requested; it equals the internal pc.
REQ-009 imem_rdata  in  32  SHALL be the instruction word for imem_addr, valid when imem_ack=1 in the same cycle.
REQ-010 imem_ack  in  1  SHALL be memory acknowledge; it may arrive any number of cycles after imem_req.
REQ-011 pc_out  out  32  SHALL be the PC of the instruction on instr_out, feeding the IF/ID register.
REQ-012 instr_out  out  32  SHALL be the fetched instruction.
REQ-013 instr_valid  out  1  SHALL qualify pc_out and instr_out.
REQ-014 misalign_trap  out  1  SHALL flag a rejected misaligned redirect (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, REQ and HOLD, plus a single-entry buffer (pc and instruction).
REQ-016 IDLE: imem_req=0; next state is always REQ. IDLE lasts exactly one cycle after reset release.
REQ-017 REQ: imem_req=1 and imem_addr=pc. On imem_ack=1 with stall=0, the outputs update next edge (pc_out<=pc, instr_out<=imem_rdata, instr_valid<=1), pc<=pc+4, and the state stays REQ.
REQ-018 REQ with imem_ack=0 and stall=0 SHALL set instr_valid<=0 (bubble); pc unchanged.
REQ-019 REQ with stall=1 SHALL hold pc_out, instr_out and instr_valid. On imem_ack=1, the buffer <= {pc, imem_rdata}, pc<=pc+4 and the state goes to HOLD.
REQ-020 HOLD: imem_req=0. While stall=1, all outputs are held. When stall=0, the buffer is presented on the outputs next edge with instr_valid=1, and the state goes to REQ.
REQ-021 Redirect has highest priority in every state, above stall and imem_ack. pc<=redirect_pc, instr_valid<=0, the buffer is discarded, the state goes to REQ, and any imem_rdata acked that cycle is dropped.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Fetch latency SHALL be one cycle from imem_ack to instr_valid; sustained throughput is one instruction per cycle with single-cycle ack.
REQ-024 imem_req SHALL never be asserted in IDLE or HOLD; imem_addr SHALL be stable while imem_req=1 and no redirect occurs.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, pc=RESET_VECTOR, pc_out=RESET_VECTOR, instr_out=32'h0000_0013 (NOP), instr_valid=0, misalign_trap=0 and buffer cleared.
REQ-026 Reset asserted mid-fetch or in HOLD SHALL abandon the outstanding request; an ack arriving during reset is ignored.

Configuration
REQ-027 With macro IF_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=2'b00 SHALL NOT update pc. Instead, misalign_trap=1 for exactly one cycle (next edge), instr_valid<=0, the buffer is discarded, and fetch resumes in REQ at the unchanged pc.
REQ-028 Without IF_MISALIGN_TRAP_EN, misalign_trap SHALL be tied 0 and redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.

Verification
REQ-029 Reset release, ack held 1, rdata=32'hA000_0000+addr -> first instr_valid on cycle 3; pc_out sequence 0,4,8,... with matching instr_out.
REQ-030 ack delayed 3 cycles per request -> instr_valid pulses once per 4 cycles; pc_out increments by 4 per pulse; no duplicates.
REQ-031 stall=1 for 5 cycles with ack=1 -> outputs frozen, HOLD entered, imem_req=0. On stall release, the buffered pc/instruction appear next cycle and fetch continues with no loss.
REQ-032 redirect_en=1, redirect_pc=32'h0000_0100, concurrent with ack and stall=1 -> next cycle instr_valid=0 and imem_addr=0x100; the acked word never appears.
REQ-033 RESET_VECTOR=32'hFFFF_FFF8, ack=1 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 With IF_MISALIGN_TRAP_EN, redirect_pc=32'h0000_0102 -> misalign_trap high one cycle, imem_addr unchanged. Without the macro -> imem_addr=0x100.
